// File: rtl/pc_step_sequencer_pkg.sv
// Shared types and default constants for the PC/step sequencer.
// Optional build macro: PC_RELATIVE_EN (adds relative branch ports).
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int unsigned PC_W_DEF      = 5;
  localparam int unsigned STEP_W_DEF    = 2;
  localparam int unsigned NUM_STEPS_DEF = 4;
  localparam int unsigned RESET_PC_DEF  = 0;

endpackage

// File: rtl/pc_step_sequencer_if.sv
// Control/status bundle between the control unit and the PC/step sequencer.
// Optional build macro: PC_RELATIVE_EN (adds ld_rel and rel_off).
interface pc_step_sequencer_if #(
  parameter int unsigned PC_W   = 5,
  parameter int unsigned STEP_W = 2
);
  logic              start;
  logic              stall;
  logic              step_done;
  logic              halt;
  logic              ld_pc;
  logic [PC_W-1:0]   pc_in;
`ifdef PC_RELATIVE_EN
  logic [PC_W-1:0]   rel_off;
  logic              ld_rel;
`endif
  logic [PC_W-1:0]   pc;
  logic [STEP_W-1:0] step;
  logic              fetch;
  logic              instr_end;
  logic              running;
  logic              halted;

  modport master (
    output start, stall, step_done, halt, ld_pc, pc_in,
`ifdef PC_RELATIVE_EN
    output rel_off, ld_rel,
`endif
    input  pc, step, fetch, instr_end, running, halted
  );

  modport slave (
    input  start, stall, step_done, halt, ld_pc, pc_in,
`ifdef PC_RELATIVE_EN
    input  rel_off, ld_rel,
`endif
    output pc, step, fetch, instr_end, running, halted
  );
endinterface

// File: rtl/pc_step_sequencer_step_counter.sv
// Per-instruction step counter; term flags the last step of a full instruction.
module seq_step_counter #(
  parameter int unsigned STEP_W    = 2,
  parameter int unsigned NUM_STEPS = 4
) (
  input  logic              MClock,
  input  logic              Resetn,
  input  logic              en,
  input  logic              clr,
  output logic [STEP_W-1:0] step,
  output logic              term
);
  always_ff @(posedge MClock) begin
    if (!Resetn)  step <= '0;
    else if (clr) step <= '0;
    else if (en)  step <= step + STEP_W'(1);
  end

  assign term = (step == STEP_W'(NUM_STEPS - 1));
endmodule

// File: rtl/pc_step_sequencer.sv
// PC register and IDLE/RUN/HALT sequencer; the PC advances only at instruction end.
// Optional build macro: PC_RELATIVE_EN (adds PC-relative branch target).
module pc_step_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned STEP_W    = STEP_W_DEF,
  parameter int unsigned NUM_STEPS = NUM_STEPS_DEF,
  parameter int unsigned RESET_PC  = RESET_PC_DEF
) (
  input  logic                 MClock,
  input  logic                 Resetn,
  pc_step_sequencer_if.slave   bus
);
  seq_state_t        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_next_instr;
  logic [STEP_W-1:0] step;
  logic              term, cnt_en, cnt_clr, end_instr, fetch;

  seq_step_counter #(
    .STEP_W    (STEP_W),
    .NUM_STEPS (NUM_STEPS)
  ) u_step (
    .MClock (MClock),
    .Resetn (Resetn),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .step   (step),
    .term   (term)
  );

  always_ff @(posedge MClock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Absolute load beats relative, which beats sequential increment.
  always_comb begin
    pc_next_instr = pc_q + PC_W'(1);
`ifdef PC_RELATIVE_EN
    if (bus.ld_rel) pc_next_instr = pc_q + bus.rel_off;
`endif
    if (bus.ld_pc) pc_next_instr = bus.pc_in;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    end_instr = 1'b0;
    fetch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.halt)       state_d = HALT;
        else if (bus.start) state_d = RUN;
      end
      RUN: begin
        fetch = !bus.stall && (step == '0);
        if (bus.halt) begin
          state_d = HALT;
        end else if (!bus.stall) begin
          if (term || bus.step_done) begin
            end_instr = 1'b1;
            cnt_clr   = 1'b1;
            pc_d      = pc_next_instr;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc        = pc_q;
  assign bus.step      = step;
  assign bus.fetch     = fetch;
  assign bus.instr_end = end_instr;
  assign bus.running   = (state_q == RUN);
  assign bus.halted    = (state_q == HALT);
endmodule

// File: tb/tb_pc_step_sequencer.sv
// Directed-vector bench for pc_step_sequencer with a queue-based output scoreboard.
module tb_pc_step_sequencer;
  logic MClock = 1'b0;
  logic Resetn = 1'b0;

  pc_step_sequencer_if #(.PC_W(5), .STEP_W(2)) bus ();

  pc_step_sequencer #(
    .PC_W      (5),
    .STEP_W    (2),
    .NUM_STEPS (4),
    .RESET_PC  (3)
  ) dut (
    .MClock (MClock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 MClock = ~MClock;

  typedef struct {
    int unsigned id;
    logic [4:0]  pc;
    logic [1:0]  step;
    logic        f, ie, r, h;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int unsigned vec_id = 0;

  task automatic cyc(input logic rst, input logic st, input logic stl, input logic sd,
                     input logic hl, input logic lp, input logic [4:0] pin,
                     input logic lr, input logic [4:0] roff, input logic chk,
                     input logic [4:0] epc, input logic [1:0] est,
                     input logic ef, input logic eie, input logic er, input logic eh);
    exp_t e;
    @(negedge MClock);
    Resetn        = rst;
    bus.start     = st;
    bus.stall     = stl;
    bus.step_done = sd;
    bus.halt      = hl;
    bus.ld_pc     = lp;
    bus.pc_in     = pin;
`ifdef PC_RELATIVE_EN
    bus.ld_rel    = lr;
    bus.rel_off   = roff;
`endif
    if (chk) begin
      e.id = vec_id; e.pc = epc; e.step = est;
      e.f = ef; e.ie = eie; e.r = er; e.h = eh;
      exp_q.push_back(e);
    end
    vec_id++;
  endtask

  initial begin : monitor
    exp_t e;
    logic [10:0] act, req;
    forever begin
      @(negedge MClock);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.pc, bus.step, bus.fetch, bus.instr_end, bus.running, bus.halted};
        req = {e.pc, e.step, e.f, e.ie, e.r, e.h};
        checks++;
        if (act !== req) begin
          errors++;
          $display("FAIL vec%0d {pc,step,fetch,instr_end,running,halted} actual=%h/%0d/%b%b%b%b required=%h/%0d/%b%b%b%b",
                   e.id, act[10:6], act[5:4], act[3], act[2], act[1], act[0],
                   req[10:6], req[5:4], req[3], req[2], req[1], req[0]);
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned budget;
    bus.start = 0; bus.stall = 0; bus.step_done = 0; bus.halt = 0;
    bus.ld_pc = 0; bus.pc_in = '0;
`ifdef PC_RELATIVE_EN
    bus.ld_rel = 0; bus.rel_off = '0;
`endif
    //  rst st stl sd hl lp pin    lr roff  chk  pc     st f ie r h
    cyc(0, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0,  0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  2, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  3, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd4,  0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd4,  1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd4,  2, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd4,  3, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd5,  0, 1, 0, 1, 0);
    // early end at step 1 with absolute branch
    cyc(1, 0, 0, 1, 0, 1, 5'h12, 0, 5'd0, 1, 5'd5,  1, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 5'd7,  0, 5'd0, 1, 5'h12, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'h12, 1, 0, 0, 1, 0);
    // three stall cycles at step 2
    cyc(1, 0, 1, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'h12, 2, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 0, 0, 5'd0,  0, 5'd0, 1, 5'h12, 2, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'h12, 2, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'h12, 2, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 5'd31, 0, 5'd0, 1, 5'h12, 3, 0, 1, 1, 0);
    // stall at step 0 suppresses fetch; then one-cycle instruction wraps pc 31->0
    cyc(1, 0, 1, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd31, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 0, 5'd0,  0, 5'd0, 1, 5'd31, 0, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd0,  0, 1, 0, 1, 0);
    // halt with stall at step 1; start ignored in HALT; reset back to IDLE
    cyc(1, 0, 1, 0, 1, 0, 5'd0,  0, 5'd0, 1, 5'd0,  1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd0,  1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 1, 5'd9,  0, 5'd0, 1, 5'd0,  1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd0,  1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 5'd0,  0, 5'd0, 1, 5'd3,  0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd3,  0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 1, 5'd10, 0, 5'd0, 1, 5'd3,  0, 1, 1, 1, 0);
`ifdef PC_RELATIVE_EN
    // relative branch 10 + (-4) = 6, then absolute load overrides relative
    cyc(1, 0, 0, 1, 0, 0, 5'd0,  1, 5'h1C, 1, 5'd10, 0, 1, 1, 1, 0);
    cyc(1, 0, 0, 1, 0, 1, 5'd20, 1, 5'h1C, 1, 5'd6,  0, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 5'd20, 0, 1, 0, 1, 0);
`else
    cyc(1, 0, 0, 0, 0, 0, 5'd0,  0, 5'd0, 1, 5'd10, 0, 1, 0, 1, 0);
`endif
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge MClock);
      budget++;
    end
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
